instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Encodes decoded RV32I instruction fields into 32-bit words and writes them to sequential instruction-memory addresses.
// Latency: wr_en rises the cycle after a field transfer; one instruction accepted every 2 cycles.
// Backpressure: in_ready drops while emitting, while full (count == DEPTH) and while clear is asserted.
module instr_encoder #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_kind,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7b5,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    // Instruction kinds as presented on in_kind.
    localparam logic [2:0] K_LW   = 3'd0;
    localparam logic [2:0] K_SW   = 3'd1;
    localparam logic [2:0] K_R    = 3'd2;
    localparam logic [2:0] K_B    = 3'd3;
    localparam logic [2:0] K_IALU = 3'd4;
    localparam logic [2:0] K_JALR = 3'd5;
    localparam logic [2:0] K_JAL  = 3'd6;
    localparam logic [2:0] K_ILL  = 3'd7;

    // RV32I major opcodes.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE        = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [AW:0] r_count;
    logic        r_err;
    logic [31:0] r_data;

    logic        w_full;
    logic        w_ready;
    logic        w_take;
    logic        w_take_legal;
    logic        w_take_ill;
    logic        w_wr_en;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_shift;
    logic [31:0] w_enc;

    // Upper immediate bits never reach any encoding; kept visible only to mark them intentionally unused.
    logic        w_unused_imm;
    assign w_unused_imm = ^in_imm[31:21];

    assign w_full       = (r_count == FULL_COUNT);
    assign w_ready      = (r_state == S_IDLE) && !w_full && !clear;
    assign w_take       = in_valid && w_ready;
    assign w_take_legal = w_take && (in_kind != K_ILL);
    assign w_take_ill   = w_take && (in_kind == K_ILL);
    // A clear landing on the EMIT cycle suppresses the write so the restart leaves memory untouched.
    assign w_wr_en      = (r_state == S_EMIT) && !clear;

    // Select opcode and funct3 for the requested kind; loads/stores are always word-sized, jalr uses funct3 000.
    always_comb begin
        w_opcode = OP_IMM;
        w_funct3 = in_funct3;
        case (in_kind)
            K_LW:    begin w_opcode = OP_LOAD;   w_funct3 = 3'b010; end
            K_SW:    begin w_opcode = OP_STORE;  w_funct3 = 3'b010; end
            K_R:     w_opcode = OP_REG;
            K_B:     w_opcode = OP_BRANCH;
            K_IALU:  w_opcode = OP_IMM;
            K_JALR:  begin w_opcode = OP_JALR;   w_funct3 = 3'b000; end
            K_JAL:   w_opcode = OP_JAL;
            default: w_opcode = OP_IMM;
        endcase
    end

    // funct7 only carries bit 30 (sub/sra/srai); shift-immediates reuse it in the upper immediate slot.
    assign w_funct7 = {1'b0, in_funct7b5, 5'b00000};
    assign w_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // Assemble the instruction word per format; fields a format does not use are left zero.
    always_comb begin
        w_enc = 32'h0000_0000;
        case (in_kind)
            K_R: begin
                w_enc = {w_funct7, in_rs2, in_rs1, w_funct3, in_rd, w_opcode};
            end
            K_LW, K_JALR: begin
                w_enc = {in_imm[11:0], in_rs1, w_funct3, in_rd, w_opcode};
            end
            K_IALU: begin
                if (w_shift) begin
                    w_enc = {w_funct7, in_imm[4:0], in_rs1, w_funct3, in_rd, w_opcode};
                end else begin
                    w_enc = {in_imm[11:0], in_rs1, w_funct3, in_rd, w_opcode};
                end
            end
            K_SW: begin
                w_enc = {in_imm[11:5], in_rs2, in_rs1, w_funct3, in_imm[4:0], w_opcode};
            end
            K_B: begin
                // imm[0] is dropped: branch offsets are always even.
                w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_funct3,
                         in_imm[4:1], in_imm[11], w_opcode};
            end
            K_JAL: begin
                w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_opcode};
            end
            default: begin
                w_enc = 32'h0000_0000;
            end
        endcase
    end

    // State register; reset drops any pending EMIT so no write follows reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: a legal transfer enters EMIT for one cycle; illegal kinds stay in IDLE; clear always wins.
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = w_take_legal ? S_EMIT : S_IDLE;
                S_EMIT:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Word counter advances on each write; it never exceeds DEPTH because transfers stop while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_wr_en) begin
            r_count <= r_count + ONE;
        end
    end

    // Sticky flag for an accepted illegal kind, cleared only by reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (clear) begin
            r_err <= 1'b0;
        end else if (w_take_ill) begin
            r_err <= 1'b1;
        end
    end

    // Capture the encoded word at transfer; it stays on wr_data until the next legal transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 32'h0000_0000;
        end else if (w_take_legal) begin
            r_data <= w_enc;
        end
    end

    assign in_ready = w_ready;
    assign wr_en    = w_wr_en;
    assign wr_addr  = r_count[AW-1:0];
    assign wr_data  = r_data;
    assign count    = r_count;
    assign full     = w_full;
    assign err      = r_err;

endmodule
